// File: rtl/oneshot_pulse_timer.sv
// Retriggerable-optional monostable: synchronised trigger edge -> q/q_n pulse, hold-off, miss counter.
// Optional retrigger support is enabled by defining ONESHOT_RETRIGGER_EN.
module oneshot_pulse_timer #(
  parameter int WIDTH_W     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RECOVERY    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a1_n,
  input  logic               a2_n,
  input  logic               b,
  input  logic [WIDTH_W-1:0] width,
  input  logic               clear_n,
  output logic               q,
  output logic               q_n,
  output logic               busy,
  output logic [7:0]         miss_cnt
);

  localparam int RCNT_W = (RECOVERY > 1) ? $clog2(RECOVERY + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] a1_sync_q;
  logic [SYNC_STAGES-1:0] a2_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;
  logic                   t_prev_q;
  logic                   t_sync_s;
  logic                   trig_s;
  logic                   retrig_s;
  logic                   miss_inc_s;
  logic [7:0]             miss_d;

  state_e                 state_q;
  logic [WIDTH_W-1:0]     cnt_q;
  logic [RCNT_W-1:0]      rcnt_q;
  logic                   q_q;
  logic                   q_n_q;
  logic                   busy_q;
  logic [7:0]             miss_q;

  // Pin synchronisers and the edge-detect history register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a1_sync_q <= '0;
      a2_sync_q <= '0;
      b_sync_q  <= '0;
      t_prev_q  <= 1'b0;
    end else begin
      a1_sync_q <= {a1_sync_q[SYNC_STAGES-2:0], a1_n};
      a2_sync_q <= {a2_sync_q[SYNC_STAGES-2:0], a2_n};
      b_sync_q  <= {b_sync_q[SYNC_STAGES-2:0], b};
      t_prev_q  <= t_sync_s;
    end
  end

  // Qualified trigger level from synchronised pins, and its rising edge
  always_comb begin
    t_sync_s = (~a1_sync_q[SYNC_STAGES-1] | ~a2_sync_q[SYNC_STAGES-1]) & b_sync_q[SYNC_STAGES-1];
    trig_s   = t_sync_s & ~t_prev_q;
  end

  // Retrigger acceptance and rejected-trigger detection; clear swallows the trigger
  always_comb begin
    miss_inc_s = 1'b0;
`ifdef ONESHOT_RETRIGGER_EN
    retrig_s = trig_s & (width != '0);
`else
    retrig_s = 1'b0;
`endif
    if (clear_n && trig_s) begin
      case (state_q)
        ST_IDLE:    miss_inc_s = (width == '0);
        ST_PULSE:   miss_inc_s = ~retrig_s;
        ST_RECOVER: miss_inc_s = 1'b1;
        default:    miss_inc_s = 1'b0;
      endcase
    end else begin
      miss_inc_s = 1'b0;
    end
    if (miss_inc_s && (miss_q != 8'hFF)) begin
      miss_d = miss_q + 8'd1;
    end else begin
      miss_d = miss_q;
    end
  end

  // Pulse FSM with registered q/q_n/busy and the saturating miss counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      q_q     <= 1'b0;
      q_n_q   <= 1'b1;
      busy_q  <= 1'b0;
      miss_q  <= 8'd0;
    end else begin
      miss_q <= miss_d;
      if (!clear_n) begin
        state_q <= ST_IDLE;
        q_q     <= 1'b0;
        q_n_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trig_s && (width != '0)) begin
              cnt_q   <= width;
              state_q <= ST_PULSE;
              q_q     <= 1'b1;
              q_n_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          ST_PULSE: begin
            if (retrig_s) begin
              cnt_q <= width;
            end else if (cnt_q == WIDTH_W'(1)) begin
              q_q   <= 1'b0;
              q_n_q <= 1'b1;
              if (RECOVERY == 0) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ST_RECOVER;
                rcnt_q  <= RCNT_W'(RECOVERY);
                busy_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - WIDTH_W'(1);
            end
          end
          ST_RECOVER: begin
            if (rcnt_q == RCNT_W'(1)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              rcnt_q <= rcnt_q - RCNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            q_q     <= 1'b0;
            q_n_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign q        = q_q;
  assign q_n      = q_n_q;
  assign busy     = busy_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_oneshot_pulse_timer.sv
// Directed bench for oneshot_pulse_timer: timestamp-based reference model checked every cycle.
module tb_oneshot_pulse_timer;
  localparam int WW  = 8;
  localparam int SS  = 2;
  localparam int REC = 2;
`ifdef ONESHOT_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a1_n = 1'b1;
  logic          a2_n = 1'b1;
  logic          b = 1'b1;
  logic [WW-1:0] width = 8'd5;
  logic          clear_n = 1'b1;
  logic          q, q_n, busy;
  logic [7:0]    miss_cnt;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int q_end = 0;
  int busy_end = 0;
  int miss_m = 0;
  bit hist [0:SS];
  bit chk_en = 1'b0;
  int run_cnt = 0;
  int last_run = 0;

  oneshot_pulse_timer #(.WIDTH_W(WW), .SYNC_STAGES(SS), .RECOVERY(REC)) dut (
    .clk(clk), .rst_n(rst_n), .a1_n(a1_n), .a2_n(a2_n), .b(b), .width(width),
    .clear_n(clear_n), .q(q), .q_n(q_n), .busy(busy), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the pulse is a pair of end timestamps; pins reach the edge detector SS edges late.
  task automatic model_step();
    int prev;
    bit trig;
    bit samp;
    edge_n++;
    prev = edge_n - 1;
    if (!rst_n) begin
      q_end = edge_n;
      busy_end = edge_n;
      miss_m = 0;
      for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
    end else begin
      trig = hist[SS-1] && !hist[SS];
      samp = (!a1_n || !a2_n) && b;
      for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = samp;
      if (!clear_n) begin
        q_end = edge_n;
        busy_end = edge_n;
      end else if (trig) begin
        if (prev >= busy_end) begin
          if (width != 0) begin
            q_end = edge_n + int'(width);
            busy_end = q_end + REC;
          end else begin
            miss_m++;
          end
        end else if (prev < q_end && RETRIG && width != 0) begin
          q_end = edge_n + int'(width);
          busy_end = q_end + REC;
        end else begin
          miss_m++;
        end
        if (miss_m > 255) miss_m = 255;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("q", int'(q), int'(edge_n < q_end));
      chk("q_n", int'(q_n), int'(!(edge_n < q_end)));
      chk("busy", int'(busy), int'(edge_n < busy_end));
      chk("miss_cnt", int'(miss_cnt), miss_m);
    end
    if (q === 1'b1) begin
      run_cnt++;
    end else if (run_cnt != 0) begin
      last_run = run_cnt;
      run_cnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One-cycle low pulse on a trigger pin, followed by one idle cycle
  task automatic fire(input bit use_a2);
    if (use_a2) a2_n = 1'b0; else a1_n = 1'b0;
    tick(1);
    a1_n = 1'b1;
    a2_n = 1'b1;
    tick(1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      a1_n = ~a1_n;
      tick(1);
      chk_en = 1'b1;
      chk("rst_q", int'(q), 0);
      chk("rst_q_n", int'(q_n), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_miss", int'(miss_cnt), 0);
    end
    a1_n = 1'b1;
    rst_n = 1'b1;
    tick(6);
    chk("no_pulse_after_rst", int'(q), 0);

    width = 8'd5;
    a1_n = 1'b0;
    tick(2);
    chk("lat_edge2", int'(q), 0);
    tick(1);
    chk("lat_edge3", int'(q), 1);
    a1_n = 1'b1;
    tick(4);
    chk("pulse_last", int'(q), 1);
    tick(1);
    chk("pulse_end_q", int'(q), 0);
    chk("recover1_busy", int'(busy), 1);
    tick(1);
    chk("recover2_busy", int'(busy), 1);
    tick(1);
    chk("idle_busy", int'(busy), 0);
    chk("basic_len", last_run, 5);

    width = 8'd10;
    fire(1'b0);
    tick(2);
    fire(1'b1);
    tick(20);
    chk("pulse_trig_len", last_run, RETRIG ? 14 : 10);
    chk("pulse_trig_miss", int'(miss_cnt), RETRIG ? 0 : 1);

    width = 8'd3;
    fire(1'b0);
    tick(2);
    fire(1'b1);
    tick(10);
    chk("recover_miss", int'(miss_cnt), RETRIG ? 1 : 2);
    fire(1'b0);
    tick(3);
    fire(1'b1);
    tick(10);
    chk("recover_exit_miss", int'(miss_cnt), RETRIG ? 2 : 3);

    width = 8'd8;
    fire(1'b0);
    tick(1);
    fire(1'b1);
    clear_n = 1'b0;
    tick(1);
    chk("clear_q", int'(q), 0);
    chk("clear_busy", int'(busy), 0);
    chk("clear_miss", int'(miss_cnt), RETRIG ? 2 : 3);
    clear_n = 1'b1;
    tick(1);
    chk("clear_no_recover", int'(busy), 0);
    tick(3);
    chk("clear_no_restart", int'(q), 0);

    width = 8'd0;
    fire(1'b0);
    tick(3);
    chk("w0_miss", int'(miss_cnt), RETRIG ? 3 : 4);
    chk("w0_q", int'(q), 0);

    width = 8'd10;
    fire(1'b0);
    tick(2);
    width = 8'd0;
    fire(1'b1);
    tick(20);
    chk("width_change_len", last_run, 10);
    chk("width_change_miss", int'(miss_cnt), RETRIG ? 4 : 5);

    width = RETRIG ? 8'd0 : 8'd200;
    for (int i = 0; i < 300; i++) fire(i[0]);
    tick(5);
    chk("sat_255", int'(miss_cnt), 255);
    fire(1'b0);
    fire(1'b1);
    tick(2);
    chk("sat_hold", int'(miss_cnt), 255);
    tick(220);

    width = 8'd200;
    fire(1'b0);
    tick(3);
    chk("pre_rst_q", int'(q), 1);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_q", int'(q), 0);
    chk("midrst_q_n", int'(q_n), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_miss", int'(miss_cnt), 0);
    rst_n = 1'b1;
    tick(5);
    chk("midrst_no_recover", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
